// File: rtl/game_sequencer.sv
// Breakout game controller: serve/play/lost/level-clear sequencing, lives, score, level and block count.
// Optional PAUSE state enabled by defining PAUSE_SEL_EN.
module game_sequencer #(
  parameter int LIVES       = 3,
  parameter int N_BLOCKS    = 40,
  parameter int SERVE_TICKS = 60,
  parameter int MAX_LEVEL   = 4,
  parameter int PTS_BLOCK   = 10,
  parameter int SCORE_W     = 14
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               tick,
  input  logic               ball_lost,
  input  logic               block_hit,
  output logic               ball_run,
  output logic               ball_hold,
  output logic               blocks_reload,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         level,
  output logic [2:0]         state,
  output logic               game_over,
  output logic               game_won
);

  localparam int BW = $clog2(N_BLOCKS + 1);
  localparam int CW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_SERVE       = 3'd1,
    S_PLAY        = 3'd2,
    S_LOST        = 3'd3,
    S_LEVEL_CLEAR = 3'd4,
    S_GAME_OVER   = 3'd5,
    S_WIN         = 3'd6,
    S_PAUSE       = 3'd7
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               r_start_q;
  logic [2:0]         r_lives;
  logic [SCORE_W-1:0] r_score;
  logic [2:0]         r_level;
  logic [BW-1:0]      r_blocks_left;
  logic [CW-1:0]      r_serve_cnt;
  logic               r_ball_run;
  logic               r_ball_hold;
  logic               r_blocks_reload;
  logic               r_game_over;
  logic               r_game_won;

  logic               w_start_rise;
  logic               w_start_load;
  logic               w_hit_ok;
  logic               w_last_block;
  logic               w_serve_done;
  logic               w_at_max_level;
  logic               w_ball_run;
  logic               w_ball_hold;
  logic               w_blocks_reload;
  logic [SCORE_W:0]   w_score_sum;
  logic [SCORE_W-1:0] w_score_next;

  assign w_start_rise   = start_btn & ~r_start_q;
  assign w_start_load   = w_start_rise &&
                          (r_state == S_IDLE || r_state == S_GAME_OVER || r_state == S_WIN);
  assign w_hit_ok       = (r_state == S_PLAY) && block_hit && (r_blocks_left != '0);
  assign w_last_block   = w_hit_ok && (r_blocks_left == BW'(1));
  assign w_serve_done   = (r_state == S_SERVE) && tick && (r_serve_cnt == CW'(SERVE_TICKS - 1));
  assign w_at_max_level = (r_level == 3'(MAX_LEVEL));
  assign w_score_sum    = {1'b0, r_score} + (SCORE_W + 1)'(PTS_BLOCK);
  assign w_score_next   = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_GAME_OVER, S_WIN:
        if (w_start_rise) w_next_state = S_SERVE;
      S_SERVE:
        if (w_serve_done) w_next_state = S_PLAY;
      S_PLAY: begin
        if (w_last_block)   w_next_state = S_LEVEL_CLEAR;
        else if (ball_lost) w_next_state = S_LOST;
`ifdef PAUSE_SEL_EN
        else if (w_start_rise) w_next_state = S_PAUSE;
`endif
      end
      S_LOST:
        w_next_state = (r_lives <= 3'd1) ? S_GAME_OVER : S_SERVE;
      S_LEVEL_CLEAR:
        w_next_state = w_at_max_level ? S_WIN : S_SERVE;
`ifdef PAUSE_SEL_EN
      S_PAUSE:
        if (w_start_rise) w_next_state = S_PLAY;
`endif
      default:
        w_next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with the state code.
  always_comb begin
    w_ball_run      = (w_next_state == S_PLAY) || (w_next_state == S_PAUSE);
`ifdef PAUSE_SEL_EN
    w_ball_hold     = (w_next_state == S_PAUSE);
`else
    w_ball_hold     = 1'b0;
`endif
    w_blocks_reload = w_start_load || ((r_state == S_LEVEL_CLEAR) && !w_at_max_level);
  end

  // NOTE: every register, counters included, is cleared by the asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ball_run      <= 1'b0;
      r_ball_hold     <= 1'b0;
      r_blocks_reload <= 1'b0;
      r_game_over     <= 1'b0;
      r_game_won      <= 1'b0;
      r_start_q       <= 1'b0;
    end else begin
      r_ball_run      <= w_ball_run;
      r_ball_hold     <= w_ball_hold;
      r_blocks_reload <= w_blocks_reload;
      r_game_over     <= (w_next_state == S_GAME_OVER);
      r_game_won      <= (w_next_state == S_WIN);
      r_start_q       <= start_btn;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lives       <= '0;
      r_score       <= '0;
      r_level       <= '0;
      r_blocks_left <= '0;
    end else if (w_start_load) begin
      r_lives       <= 3'(LIVES);
      r_score       <= '0;
      r_level       <= 3'd1;
      r_blocks_left <= BW'(N_BLOCKS);
    end else begin
      case (r_state)
        S_PLAY:
          if (w_hit_ok) begin
            r_score       <= w_score_next;
            r_blocks_left <= r_blocks_left - BW'(1);
          end
        S_LOST:
          r_lives <= (r_lives <= 3'd1) ? 3'd0 : r_lives - 3'd1;
        S_LEVEL_CLEAR:
          if (!w_at_max_level) begin
            r_level       <= r_level + 3'd1;
            r_blocks_left <= BW'(N_BLOCKS);
          end
        default: ;
      endcase
    end
  end

  // Serve counter only advances inside SERVE and is parked at zero everywhere else.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                  r_serve_cnt <= '0;
    else if (r_state != S_SERVE) r_serve_cnt <= '0;
    else if (w_serve_done)       r_serve_cnt <= '0;
    else if (tick)               r_serve_cnt <= r_serve_cnt + CW'(1);
  end

  assign ball_run      = r_ball_run;
  assign ball_hold     = r_ball_hold;
  assign blocks_reload = r_blocks_reload;
  assign lives         = r_lives;
  assign score         = r_score;
  assign level         = r_level;
  assign state         = r_state;
  assign game_over     = r_game_over;
  assign game_won      = r_game_won;

endmodule
